cpu_oci_dct_unpacker: RTL and testbench

- Consumer end of the OCI trace compression buffer. The packer produces 30-bit dct_buffer words. Each word holds up to 15 packed 2-bit trace codes, and dct_count gives the number of valid codes.
- This block accepts those words over a valid/ready handshake and replays the codes one per cycle, LSB-first, on a streaming output.
- It feeds the simulation trace checker and the off-chip trace formatter.
- It also turns the test_ending request into a drained test_has_ended indication.

---
 rtl/cpu_oci_dct_unpacker.sv | 132 +++++++++++++
 tb/tb_cpu_oci_dct_unpacker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oci_dct_unpacker.sv
// Consumer end of the OCI trace compression buffer: unpacks buffer words into a
// one-code-per-cycle stream and turns test_ending into a drained test_has_ended.
module cpu_oci_dct_unpacker #(
    parameter int unsigned CODE_W    = 2,
    parameter int unsigned NUM_CODES = 15,
    parameter int unsigned BUF_W     = 30,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned TOT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BUF_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    input  logic              test_ending,
    output logic              test_has_ended,
    output logic [TOT_W-1:0]  code_total,
    output logic [15:0]       empty_words
);

    typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;

    state_t           state;
    state_t           state_next;
    logic             started;
    logic [BUF_W-1:0] sr;
    logic [CNT_W-1:0] rc;
    logic [BUF_W-1:0] pr;
    logic [CNT_W-1:0] pr_cnt;
    logic             pr_valid;
    logic [BUF_W-1:0] in_masked;
    logic             accept;
    logic             accept_word;
    logic             fire;
    logic             sr_free;

    assign in_ready       = started && !pr_valid && (state == RUN);
    assign out_valid      = (rc != '0);
    assign out_code       = sr[CODE_W-1:0];
    assign out_last       = (rc == CNT_W'(1));
    assign test_has_ended = (state == ENDED);

    assign accept      = in_valid && in_ready;
    assign accept_word = accept && (dct_count != '0);
    assign fire        = out_valid && out_ready;
    assign sr_free     = (rc == '0) || ((rc == CNT_W'(1)) && fire);

    // Slots beyond dct_count are zeroed so the shift register never carries stale codes.
    always_comb begin
        in_masked = '0;
        for (int unsigned i = 0; i < NUM_CODES; i++) begin
            if (i < 32'(dct_count)) begin
                in_masked[i*CODE_W +: CODE_W] = dct_buffer[i*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (test_ending) state_next = DRAIN;
            DRAIN:   if ((rc == '0) && !pr_valid) state_next = ENDED;
            ENDED:   state_next = ENDED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    // A pending word takes priority for a freed SR; in_ready is low whenever PR holds one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr       <= '0;
            rc       <= '0;
            pr       <= '0;
            pr_cnt   <= '0;
            pr_valid <= 1'b0;
        end else begin
            if (sr_free) begin
                if (pr_valid) begin
                    sr       <= pr;
                    rc       <= pr_cnt;
                    pr_valid <= 1'b0;
                end else if (accept_word) begin
                    sr <= in_masked;
                    rc <= dct_count;
                end else if (fire) begin
                    sr <= sr >> CODE_W;
                    rc <= rc - CNT_W'(1);
                end
            end else begin
                if (fire) begin
                    sr <= sr >> CODE_W;
                    rc <= rc - CNT_W'(1);
                end
                if (accept_word) begin
                    pr       <= in_masked;
                    pr_cnt   <= dct_count;
                    pr_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_total  <= '0;
            empty_words <= '0;
        end else begin
            if (fire && !(&code_total)) begin
                code_total <= code_total + TOT_W'(1);
            end
            if (accept && (dct_count == '0) && !(&empty_words)) begin
                empty_words <= empty_words + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_oci_dct_unpacker.sv
// Bench for cpu_oci_dct_unpacker: queue-based model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_cpu_oci_dct_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_code;
    logic        out_last;
    logic        test_ending = 1'b0;
    logic        test_has_ended;
    logic [31:0] code_total;
    logic [15:0] empty_words;

    cpu_oci_dct_unpacker #(
        .CODE_W(2), .NUM_CODES(15), .BUF_W(30), .CNT_W(4), .TOT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_last(out_last),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .code_total(code_total), .empty_words(empty_words)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of codes still owed downstream, each tagged with whether it ends its word.
    int          m_codes[$];
    bit          m_lasts[$];
    bit          m_started = 0;
    bit          m_ending = 0;
    bit          m_ended = 0;
    logic [31:0] m_total = '0;
    logic [15:0] m_empty = '0;
    bit          m_rdy, m_val, m_was_empty, m_prev_ending;
    logic [29:0] m_word;

    function automatic int words_held();
        int n = 0;
        foreach (m_lasts[k]) if (m_lasts[k]) n++;
        return n;
    endfunction

    function automatic bit model_in_ready();
        return m_started && (words_held() < 2) && !m_ending;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_codes.delete();
            m_lasts.delete();
            m_started = 0;
            m_ending  = 0;
            m_ended   = 0;
            m_total   = '0;
            m_empty   = '0;
        end else begin
            m_rdy         = model_in_ready();
            m_val         = (m_codes.size() != 0);
            m_was_empty   = !m_val;
            m_prev_ending = m_ending;
            if (m_val && out_ready) begin
                void'(m_codes.pop_front());
                void'(m_lasts.pop_front());
                if (m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
            end
            if (in_valid && m_rdy) begin
                if (dct_count == 0) begin
                    if (m_empty != 16'hFFFF) m_empty = m_empty + 1;
                end else begin
                    m_word = dct_buffer;
                    for (int k = 0; k < int'(dct_count); k++) begin
                        m_codes.push_back(int'((m_word >> (2 * k)) & 30'd3));
                        m_lasts.push_back(k == int'(dct_count) - 1);
                    end
                end
            end
            if (m_prev_ending && m_was_empty) m_ended = 1;
            if (test_ending) m_ending = 1;
            m_started = 1;
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, model_in_ready());
        check("out_valid", out_valid, m_codes.size() != 0);
        check("out_last", out_last, (m_codes.size() != 0) ? m_lasts[0] : 1'b0);
        if (m_codes.size() != 0) check("out_code", out_code, m_codes[0]);
        check("test_has_ended", test_has_ended, m_ended);
        check("code_total", code_total, m_total);
        check("empty_words", empty_words, m_empty);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_code_total", code_total, 0);
        reset = 1'b0;
        step();

        // single word: codes 0,1,2,3
        out_ready = 1'b1;
        in_valid = 1'b1; dct_buffer = 30'h0000_00E4; dct_count = 4'd4;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_code", out_code, i);
            check("t1_last", out_last, i == 3);
            step();
        end
        check("t1_idle", out_valid, 0);
        check("t1_total", code_total, 4);

        // back-to-back full words
        in_valid = 1'b1; dct_buffer = 30'h2B3C_4D5E; dct_count = 4'd15;
        step();
        dct_buffer = 30'h1A2B_3C4D;
        check("t2_valid", out_valid, 1);
        check("t2_last", out_last, 0);
        step();
        in_valid = 1'b0;
        check("t2_pr_full", in_ready, 0);
        for (int i = 1; i < 30; i++) begin
            check("t2_valid", out_valid, 1);
            check("t2_last", out_last, (i == 14) || (i == 29));
            step();
        end
        check("t2_idle", out_valid, 0);
        check("t2_total", code_total, 34);

        // backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; dct_buffer = 30'h0000_0039; dct_count = 4'd3;
        step();
        in_valid = 1'b0;
        check("t3_first", out_code, 1);
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2) == 1;
            step();
        end
        check("t3_idle", out_valid, 0);
        check("t3_total", code_total, 37);

        // empty words
        out_ready = 1'b1;
        in_valid = 1'b1; dct_buffer = 30'h3FFF_FFFF; dct_count = 4'd0;
        for (int i = 0; i < 3; i++) begin
            check("t4_ready", in_ready, 1);
            step();
            check("t4_no_out", out_valid, 0);
        end
        in_valid = 1'b0;
        check("t4_empty", empty_words, 3);

        // drain
        in_valid = 1'b1; dct_buffer = 30'h0000_02E4; dct_count = 4'd5;
        step();
        in_valid = 1'b0; test_ending = 1'b1;
        step();
        in_valid = 1'b1; dct_buffer = 30'h0000_1234; dct_count = 4'd7;
        check("t5_closed", in_ready, 0);
        for (int i = 0; i < 4; i++) step();
        check("t5_drained", out_valid, 0);
        check("t5_not_yet", test_has_ended, 0);
        step();
        check("t5_ended", test_has_ended, 1);
        test_ending = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("t5_sticky", test_has_ended, 1);
        check("t5_total", code_total, 42);

        // reset mid-word
        reset = 1'b1;
        #1;
        check("t6_rst_ended", test_has_ended, 0);
        step();
        reset = 1'b0;
        step();
        in_valid = 1'b1; dct_buffer = 30'h000A_BCDE; dct_count = 4'd10;
        step();
        in_valid = 1'b0;
        step(); step();
        check("t6_partial", code_total, 2);
        #2 reset = 1'b1;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_total", code_total, 0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_residue", out_valid, 0);
        end
        in_valid = 1'b1; dct_buffer = 30'h0000_0002; dct_count = 4'd1;
        step();
        in_valid = 1'b0;
        check("t6_code", out_code, 2);
        check("t6_last", out_last, 1);
        step();
        check("t6_total", code_total, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
